// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, TX/RX state enums, divider math.
// Latency: n/a (compile-time constants and pure functions only).
// Backpressure: n/a.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // Cycles per TX bit; clamped to 1 so a too-fast BAUD still yields a legal counter.
  function automatic int tx_div(input int clk_hz, input int baud);
    return (clk_hz / baud < 1) ? 1 : clk_hz / baud;
  endfunction

  // Cycles per RX oversample tick (16 ticks per bit), same clamping.
  function automatic int rx_div(input int clk_hz, input int baud);
    return (clk_hz / (16 * baud) < 1) ? 1 : clk_hz / (16 * baud);
  endfunction

  // Parity bit from the XOR of the data bits: even sends the XOR, odd its inverse.
  function automatic logic parity_bit(input logic data_xor, input int mode);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider emitting a one-cycle tick every DIV cycles; clr restarts the count.
// Latency: first tick DIV cycles after clr.
// Backpressure: none; tick is a pure strobe.
module uart_baud_gen #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap at LAST, or restart on clr so ticks align to the caller's event.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || (cnt_q == LAST)) cnt_d = '0;
  end

  assign tick = (cnt_q == LAST);

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_param.sv
// Parameterised UART: TX serialiser and 16x-oversampled RX with parity/frame/overrun flags.
// Latency: tx drops 1 cycle after accepted wr_en; rdy rises 1 cycle after the stop-bit sample.
// Backpressure: wr_en ignored while tx_busy; unread RX characters are overwritten (overrun).
module uart_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic                 rdy,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] dout,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int            TX_DIV   = tx_div(CLK_HZ, BAUD);
  localparam int            RX_DIV   = rx_div(CLK_HZ, BAUD);
  localparam int            BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam bit            HAS_PAR  = (PARITY != PAR_NONE);

  // ---------------- TX ----------------
  tx_state_t            tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_stop_q, tx_stop_d;
  logic                 tx_q, tx_d;
  logic                 tx_tick, tx_clr;

  uart_baud_gen #(.DIV(TX_DIV)) u_tx_baud (
    .clk (clk_50m), .rst (rst), .clr (tx_clr), .tick (tx_tick)
  );

  // TX next state; the line level is computed from the next state so tx is a clean flop output.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    tx_bit_d   = tx_bit_q;
    tx_par_d   = tx_par_q;
    tx_stop_d  = tx_stop_q;
    tx_clr     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: if (wr_en) begin
        tx_sh_d    = din;
        tx_par_d   = parity_bit(^din, PARITY);
        tx_clr     = 1'b1;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_tick) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
      end
      TX_DATA: if (tx_tick) begin
        if (tx_bit_q == LAST_BIT) begin
          tx_state_d = HAS_PAR ? TX_PARITY : TX_STOP;
          tx_stop_d  = 1'b0;
        end else begin
          tx_bit_d = tx_bit_q + BW'(1);
          tx_sh_d  = tx_sh_q >> 1;
        end
      end
      TX_PARITY: if (tx_tick) begin
        tx_state_d = TX_STOP;
        tx_stop_d  = 1'b0;
      end
      TX_STOP: if (tx_tick) begin
        if (tx_stop_q || (STOP_BITS == 1)) tx_state_d = TX_IDLE;
        else                               tx_stop_d  = 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase

    tx_d = 1'b1;
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_sh_d[0];
      TX_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // TX registers; reset drives the line idle-high immediately.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= '0;
      tx_bit_q   <= '0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sh_q    <= tx_sh_d;
      tx_bit_q   <= tx_bit_d;
      tx_par_q   <= tx_par_d;
      tx_stop_q  <= tx_stop_d;
      tx_q       <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_state_q != TX_IDLE);

  // ---------------- RX ----------------
  rx_state_t            rx_state_q, rx_state_d;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [3:0]           rx_tick_q, rx_tick_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 rdy_q, rdy_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 rx_tick, rx_clr, rx_mid;

  uart_baud_gen #(.DIV(RX_DIV)) u_rx_baud (
    .clk (clk_50m), .rst (rst), .clr (rx_clr), .tick (rx_tick)
  );

  // After the start-bit check the tick count is rebased, so tick 15 lands mid-bit.
  assign rx_mid = rx_tick && (rx_tick_q == 4'd15);

  // RX next state and result flags; a completing character overrides a same-cycle rdy_clr.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick ? rx_tick_q + 4'd1 : rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    dout_d     = dout_q;
    rdy_d      = rdy_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;
    rx_clr     = 1'b0;
    if (rdy_clr) begin
      rdy_d  = 1'b0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end
    unique case (rx_state_q)
      RX_IDLE: if (!rx_s2_q && rx_prev_q) begin
        rx_state_d = RX_START;
        rx_clr     = 1'b1;
        rx_tick_d  = '0;
      end
      RX_START: if (rx_tick && (rx_tick_q == 4'd7)) begin
        if (rx_s2_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_DATA;
          rx_tick_d  = '0;
          rx_bit_d   = '0;
        end
      end
      RX_DATA: if (rx_mid) begin
        rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
        if (rx_bit_q == LAST_BIT) rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
        else                      rx_bit_d   = rx_bit_q + BW'(1);
      end
      RX_PARITY: if (rx_mid) begin
        rx_par_d   = rx_s2_q;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_mid) begin
        dout_d     = rx_sh_q;
        rdy_d      = 1'b1;
        ferr_d     = ~rx_s2_q;
        perr_d     = HAS_PAR && (rx_par_q != parity_bit(^rx_sh_q, PARITY));
        ovr_d      = (ovr_q | rdy_q) & ~rdy_clr;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX registers, including the two-flop synchroniser and the edge-detect history.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      dout_q     <= '0;
      rdy_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
      dout_q     <= dout_d;
      rdy_q      <= rdy_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rdy        = rdy_q;
  assign dout       = dout_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: an 8N1 instance (loopback or driven rx) and an 8E1 instance (driven rx).
// Latency: bit period is 16 clocks (TX_DIV=16, RX_DIV=1) for both instances.
// Backpressure: received characters are acknowledged with rdy_clr once the scoreboard drains.
module tb_uart_param;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  logic       clk, rst, lb;
  logic [7:0] n_din, n_dout, e_din, e_dout;
  logic       n_wr_en, n_tx, n_busy, n_rx, n_rx_drv, n_rdy, n_rdy_clr, n_perr, n_ferr, n_ovr;
  logic       e_wr_en, e_tx, e_busy, e_rx, e_rdy, e_rdy_clr, e_perr, e_ferr, e_ovr;
  logic       n_rdy_p, n_ovr_p, e_rdy_p, e_ovr_p;

  int   errors = 0;
  int   checks = 0;
  exp_t q_n[$];
  exp_t q_e[$];

  assign n_rx = lb ? n_tx : n_rx_drv;

  uart_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n (
    .clk_50m(clk), .rst(rst), .din(n_din), .wr_en(n_wr_en), .tx(n_tx), .tx_busy(n_busy),
    .rx(n_rx), .rdy(n_rdy), .rdy_clr(n_rdy_clr), .dout(n_dout), .parity_err(n_perr),
    .frame_err(n_ferr), .overrun(n_ovr));

  uart_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e (
    .clk_50m(clk), .rst(rst), .din(e_din), .wr_en(e_wr_en), .tx(e_tx), .tx_busy(e_busy),
    .rx(e_rx), .rdy(e_rdy), .rdy_clr(e_rdy_clr), .dout(e_dout), .parity_err(e_perr),
    .frame_err(e_ferr), .overrun(e_ovr));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: what a receiver must report for a frame, from the character-level rules.
  function automatic exp_t model(input logic [7:0] d, input int pm, input logic pbit,
                                 input logic stopv, input logic ov);
    exp_t r;
    logic want;
    want = ($countones(d) % 2 == 1);        // even parity bit makes total ones even
    if (pm == 1) want = ~want;
    r.d  = d;
    r.pe = (pm != 0) && (pbit != want);
    r.fe = ~stopv;
    r.ov = ov;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Monitor: a character is presented when rdy rises or overrun rises.
  task automatic monitor();
    exp_t e;
    n_rdy_p = 1'b0; n_ovr_p = 1'b0; e_rdy_p = 1'b0; e_ovr_p = 1'b0;
    forever begin
      @(negedge clk);
      if ((n_rdy && !n_rdy_p) || (n_ovr && !n_ovr_p)) begin
        if (q_n.size() == 0) chk("n_rx_unexpected", 32'({n_dout, n_perr, n_ferr, n_ovr}), 32'h7ff);
        else begin
          e = q_n.pop_front();
          chk("n_rx_char", 32'({n_dout, n_perr, n_ferr, n_ovr}), 32'(e));
        end
      end
      if ((e_rdy && !e_rdy_p) || (e_ovr && !e_ovr_p)) begin
        if (q_e.size() == 0) chk("e_rx_unexpected", 32'({e_dout, e_perr, e_ferr, e_ovr}), 32'h7ff);
        else begin
          e = q_e.pop_front();
          chk("e_rx_char", 32'({e_dout, e_perr, e_ferr, e_ovr}), 32'(e));
        end
      end
      n_rdy_p = n_rdy; n_ovr_p = n_ovr; e_rdy_p = e_rdy; e_ovr_p = e_ovr;
    end
  endtask

  task automatic send_n(input logic [7:0] b);
    @(negedge clk);
    n_din = b; n_wr_en = 1'b1;
    @(negedge clk);
    n_wr_en = 1'b0;
  endtask

  task automatic wait_n_idle();
    for (int i = 0; i < 400 && n_busy; i++) @(negedge clk);
    chk("n_busy_timeout", 32'(n_busy), 32'd0);
  endtask

  task automatic wait_drain(input bit which);
    for (int i = 0; i < 80 && ((which ? q_e.size() : q_n.size()) != 0); i++) @(negedge clk);
    chk(which ? "e_sb_drain" : "n_sb_drain", 32'(which ? q_e.size() : q_n.size()), 32'd0);
  endtask

  task automatic ack(input bit which);
    @(negedge clk);
    if (which) e_rdy_clr = 1'b1; else n_rdy_clr = 1'b1;
    @(negedge clk);
    if (which) e_rdy_clr = 1'b0; else n_rdy_clr = 1'b0;
  endtask

  // Drive one frame on a receiver input, 16 clocks per bit; parity bit only on the 8E1 instance.
  task automatic drive_frame(input bit which, input logic [7:0] d, input logic pbit, input logic stopv);
    logic [10:0] bits;
    int          nb;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (which) begin bits[9] = pbit; bits[10] = stopv; nb = 11; end
    else       begin bits[9] = stopv; nb = 10; end
    for (int k = 0; k < nb; k++) begin
      if (which) e_rx = bits[k]; else n_rx_drv = bits[k];
      repeat (16) @(negedge clk);
    end
    if (which) e_rx = 1'b1; else n_rx_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [9:0] frame;
    logic       gap;
    logic [7:0] d;
    logic       pb, sv;

    rst = 1'b1; lb = 1'b1;
    n_din = '0; n_wr_en = 1'b0; n_rx_drv = 1'b1; n_rdy_clr = 1'b0;
    e_din = '0; e_wr_en = 1'b0; e_rx = 1'b1;     e_rdy_clr = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    chk("n_reset_tx",    32'(n_tx), 32'd1);
    chk("n_reset_busy",  32'(n_busy), 32'd0);
    chk("n_reset_rx",    32'({n_rdy, n_dout, n_perr, n_ferr, n_ovr}), 32'd0);
    chk("e_reset_tx",    32'({e_tx, e_busy}), 32'b10);
    chk("e_reset_rx",    32'({e_rdy, e_dout, e_perr, e_ferr, e_ovr}), 32'd0);
    rst = 1'b0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);

    // Loopback of every character value, in order.
    for (int c = 0; c < 256; c++) begin
      q_n.push_back(model(8'(c), 0, 1'b0, 1'b1, 1'b0));
      send_n(8'(c));
      wait_n_idle();
      wait_drain(0);
      ack(0);
    end
    chk("n_last_dout", 32'(n_dout), 32'hff);

    // wr_en mid-frame is ignored: line shows 0xAA only and tx_busy never drops.
    frame = {1'b1, 8'hAA, 1'b0};
    gap   = 1'b0;
    q_n.push_back(model(8'hAA, 0, 1'b0, 1'b1, 1'b0));
    send_n(8'hAA);
    for (int c = 0; c <= 160; c++) begin
      if (c < 160 && !n_busy) gap = 1'b1;
      if (c % 16 == 8) chk("tx_wave_bit", 32'(n_tx), 32'(frame[c/16]));
      if (c == 50) begin n_din = 8'h55; n_wr_en = 1'b1; end
      if (c == 51) n_wr_en = 1'b0;
      if (c == 160) chk("tx_busy_end", 32'(n_busy), 32'd0);
      if (c < 160) @(negedge clk);
    end
    chk("tx_busy_gap", 32'(gap), 32'd0);
    wait_drain(0);
    ack(0);
    repeat (200) @(negedge clk);              // a wrongly accepted 0x55 would surface here
    chk("n_no_extra", 32'({n_busy, n_rdy}), 32'd0);

    // Overrun: two characters without acknowledge, then clear everything.
    q_n.push_back(model(8'h11, 0, 1'b0, 1'b1, 1'b0));
    send_n(8'h11);
    wait_n_idle();
    q_n.push_back(model(8'h22, 0, 1'b0, 1'b1, 1'b1));
    send_n(8'h22);
    wait_n_idle();
    wait_drain(0);
    chk("ovr_state", 32'({n_rdy, n_dout, n_ovr}), 32'({1'b1, 8'h22, 1'b1}));
    ack(0);
    chk("ovr_cleared", 32'({n_rdy, n_perr, n_ferr, n_ovr}), 32'd0);

    // Frame error on the 8N1 receiver.
    lb = 1'b0;
    q_n.push_back(model(8'h3C, 0, 1'b0, 1'b0, 1'b0));
    drive_frame(0, 8'h3C, 1'b0, 1'b0);
    wait_drain(0);
    chk("ferr_state", 32'({n_rdy, n_dout, n_ferr}), 32'({1'b1, 8'h3C, 1'b1}));
    ack(0);
    lb = 1'b1;

    // Even parity: wrong then correct parity on 0xA5.
    q_e.push_back(model(8'hA5, 2, 1'b1, 1'b1, 1'b0));
    drive_frame(1, 8'hA5, 1'b1, 1'b1);
    wait_drain(1);
    chk("perr_set", 32'({e_rdy, e_dout, e_perr}), 32'({1'b1, 8'hA5, 1'b1}));
    ack(1);
    q_e.push_back(model(8'hA5, 2, 1'b0, 1'b1, 1'b0));
    drive_frame(1, 8'hA5, 1'b0, 1'b1);
    wait_drain(1);
    chk("perr_clear", 32'({e_rdy, e_perr}), 32'b10);
    ack(1);

    // Random frames into the 8E1 receiver: random data, parity sometimes wrong, stop sometimes low.
    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      sv = ($urandom_range(0, 3) != 0);
      q_e.push_back(model(d, 2, pb, sv, 1'b0));
      drive_frame(1, d, pb, sv);
      wait_drain(1);
      ack(1);
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    // Reset during TX data bit 3 aborts the frame; a following character still loops back.
    send_n(8'hC3);
    repeat (56) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx",   32'(n_tx), 32'd1);
    chk("rst_mid_busy", 32'(n_busy), 32'd0);
    chk("rst_mid_rdy",  32'(n_rdy), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    q_n.push_back(model(8'h7E, 0, 1'b0, 1'b1, 1'b0));
    send_n(8'h7E);
    wait_n_idle();
    wait_drain(0);
    ack(0);
    repeat (40) @(negedge clk);
    chk("q_n_final", 32'(q_n.size()), 32'd0);
    chk("q_e_final", 32'(q_e.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
